// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Hazard and forwarding controller for the 5-stage core. It tracks the destination
// registers of instructions that are in flight in EX..WB in a small scoreboard.
// From that scoreboard it produces:
//   - operand forwarding selects,
//   - load-use stalls,
//   - redirect flushes,
//   - a whole-pipeline freeze while the multi-cycle unit is busy.
// It also counts stall and redirect cycles in saturating counters.

module pipe_hazard_unit #(
    parameter int DEPTH    = 3,
    parameter int FWD_W    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_we_reg,
    input  logic [4:0]       id_rdst,
    input  logic             id_mem_read,
    input  logic             ex_redirect,
    input  logic             mc_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [FWD_W-1:0] fwd_sel_rs1,
    output logic [FWD_W-1:0] fwd_sel_rs2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Scoreboard: entry 0 is EX and higher indices are older stages.
    logic [DEPTH-1:0] sb_v;
    logic [DEPTH-1:0] sb_we;
    logic [DEPTH-1:0] sb_ld;
    logic [4:0]       sb_rd [DEPTH];

    logic [DEPTH-1:0] match_rs1;
    logic [DEPTH-1:0] match_rs2;
    logic [FWD_W-1:0] fwd_rs1;
    logic [FWD_W-1:0] fwd_rs2;
    logic             lu_stall;

    // Compare each live producer against the ID operands. Register r0 never forwards.
    always_comb begin
        match_rs1 = '0;
        match_rs2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_rs1[k] = sb_v[k] & sb_we[k] & (sb_rd[k] == id_rs1) &
                           (id_rs1 != 5'd0) & id_use_rs1 & id_valid;
            match_rs2[k] = sb_v[k] & sb_we[k] & (sb_rd[k] == id_rs2) &
                           (id_rs2 != 5'd0) & id_use_rs2 & id_valid;
        end
    end

    // Pick the youngest matching entry for each operand.
    // A load that is still inside its latency window raises a load-use stall instead.
    always_comb begin
        fwd_rs1  = '0;
        fwd_rs2  = '0;
        lu_stall = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs1[k]) fwd_rs1 = FWD_W'(k + 1);
            if (match_rs2[k]) fwd_rs2 = FWD_W'(k + 1);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (k < LOAD_LAT && sb_ld[k] && (match_rs1[k] || match_rs2[k]))
                lu_stall = 1'b1;
        end
    end

    // Decode the pipeline control for this cycle.
    // The priority order is reset, freeze, redirect, stall, then run.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        fwd_sel_rs1 = fwd_rs1;
        fwd_sel_rs2 = fwd_rs2;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            fwd_sel_rs1 = '0;
            fwd_sel_rs2 = '0;
        end else if (mc_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Advance the scoreboard and the saturating counters.
    // Everything holds during a freeze, and a bubble enters EX on a redirect or stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v      <= '0;
            sb_we     <= '0;
            sb_ld     <= '0;
            for (int k = 0; k < DEPTH; k++) sb_rd[k] <= 5'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (mc_busy) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                sb_v[k]  <= sb_v[k-1];
                sb_we[k] <= sb_we[k-1];
                sb_ld[k] <= sb_ld[k-1];
                sb_rd[k] <= sb_rd[k-1];
            end
            if (ex_redirect || lu_stall) begin
                sb_v[0]  <= 1'b0;
                sb_we[0] <= 1'b0;
                sb_ld[0] <= 1'b0;
                sb_rd[0] <= 5'd0;
            end else begin
                sb_v[0]  <= id_valid;
                sb_we[0] <= id_we_reg & id_valid;
                sb_ld[0] <= id_mem_read;
                sb_rd[0] <= id_rdst;
            end
            if (ex_redirect) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (lu_stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
